// File: rtl/clk_rst_sequencer_if.sv
// Clock/reset sequencer bus: inputs that steer the sequencer and the
// sequenced reset, divided clock, strobes and timestamp it drives out.
// The optional event outputs appear only when CLK_RST_SEQ_EVT_EN is defined.
interface clk_rst_sequencer_if #(
    parameter int unsigned TIME_W = 32
);
    logic              clk_en;
    logic              sw_reset_req;
    logic              sys_reset;
    logic              div_clock;
    logic              div_rise;
    logic              div_fall;
    logic [TIME_W-1:0] timestamp;
    logic              seq_state;
`ifdef CLK_RST_SEQ_EVT_EN
    logic              evt_valid;
    logic [15:0]       evt_count;

    // Sequencer side
    modport master (
        input  clk_en, sw_reset_req,
        output sys_reset, div_clock, div_rise, div_fall, timestamp, seq_state,
               evt_valid, evt_count
    );

    // Consumer side (harness / monitor)
    modport slave (
        output clk_en, sw_reset_req,
        input  sys_reset, div_clock, div_rise, div_fall, timestamp, seq_state,
               evt_valid, evt_count
    );
`else
    // Sequencer side
    modport master (
        input  clk_en, sw_reset_req,
        output sys_reset, div_clock, div_rise, div_fall, timestamp, seq_state
    );

    // Consumer side (harness / monitor)
    modport slave (
        output clk_en, sw_reset_req,
        input  sys_reset, div_clock, div_rise, div_fall, timestamp, seq_state
    );
`endif
endinterface

// File: rtl/clk_rst_sequencer.sv
// Clock/reset sequencer for example harnesses.
//  - holds sys_reset for HOLD_CYCLES edges after reset release or a software
//    request, then releases it (HOLD -> RUN)
//  - divides the clock: div_clock toggles every HALF_PERIOD enabled cycles,
//    with registered rise/fall strobes
//  - free-running, wrapping timestamp
// Optional feature macro: CLK_RST_SEQ_EVT_EN adds evt_valid/evt_count, a pulse
// and a wrapping count of cycles on which div_clock or sys_reset changed.
// Every output comes straight from a register.
module clk_rst_sequencer #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned HALF_PERIOD = 5,
    parameter int unsigned TIME_W      = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    clk_rst_sequencer_if.master    seq_bus
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned DIV_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int unsigned EVT_W  = 16;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF_PERIOD - 1);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    seq_state_e        state_q,     state_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic              sys_reset_q, sys_reset_d;

    logic [DIV_W-1:0]  div_cnt_q,   div_cnt_d;
    logic              div_clock_q, div_clock_d;
    logic              div_rise_q,  div_rise_d;
    logic              div_fall_q,  div_fall_d;

    logic [TIME_W-1:0] ts_q,        ts_d;

`ifdef CLK_RST_SEQ_EVT_EN
    logic              evt_valid_q, evt_valid_d;
    logic [EVT_W-1:0]  evt_count_q, evt_count_d;
`endif

    // Reset-hold sequencer: a software request always restarts the hold,
    // including on the edge that would otherwise have ended it.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        sys_reset_d = sys_reset_q;

        unique case (state_q)
            ST_HOLD: begin
                sys_reset_d = 1'b1;
                if (seq_bus.sw_reset_req) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_RUN;
                    hold_cnt_d  = '0;
                    sys_reset_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                sys_reset_d = 1'b0;
                if (seq_bus.sw_reset_req) begin
                    state_d     = ST_HOLD;
                    hold_cnt_d  = '0;
                    sys_reset_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_HOLD;
                hold_cnt_d  = '0;
                sys_reset_d = 1'b1;
            end
        endcase
    end

    // Clock divider: advances only on enabled cycles, independent of the sequencer.
    always_comb begin
        div_cnt_d   = div_cnt_q;
        div_clock_d = div_clock_q;
        div_rise_d  = 1'b0;
        div_fall_d  = 1'b0;

        if (seq_bus.clk_en) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d   = '0;
                div_clock_d = ~div_clock_q;
                div_rise_d  = ~div_clock_q;
                div_fall_d  = div_clock_q;
            end else begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
        end
    end

    // Free-running timestamp, wraps naturally at its width.
    always_comb begin
        ts_d = ts_q + TIME_W'(1);
    end

`ifdef CLK_RST_SEQ_EVT_EN
    // One pulse per cycle in which either sequenced output changes value.
    always_comb begin
        evt_valid_d = (div_clock_d != div_clock_q) || (sys_reset_d != sys_reset_q);
        evt_count_d = evt_count_q + EVT_W'(evt_valid_d);
    end
`endif

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            sys_reset_q <= 1'b1;
            div_cnt_q   <= '0;
            div_clock_q <= 1'b0;
            div_rise_q  <= 1'b0;
            div_fall_q  <= 1'b0;
            ts_q        <= '0;
`ifdef CLK_RST_SEQ_EVT_EN
            evt_valid_q <= 1'b0;
            evt_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            sys_reset_q <= sys_reset_d;
            div_cnt_q   <= div_cnt_d;
            div_clock_q <= div_clock_d;
            div_rise_q  <= div_rise_d;
            div_fall_q  <= div_fall_d;
            ts_q        <= ts_d;
`ifdef CLK_RST_SEQ_EVT_EN
            evt_valid_q <= evt_valid_d;
            evt_count_q <= evt_count_d;
`endif
        end
    end

    // Outputs driven directly from registers.
    assign seq_bus.sys_reset = sys_reset_q;
    assign seq_bus.div_clock = div_clock_q;
    assign seq_bus.div_rise  = div_rise_q;
    assign seq_bus.div_fall  = div_fall_q;
    assign seq_bus.timestamp = ts_q;
    assign seq_bus.seq_state = state_q;
`ifdef CLK_RST_SEQ_EVT_EN
    assign seq_bus.evt_valid = evt_valid_q;
    assign seq_bus.evt_count = evt_count_q;
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer: reset hold/release, divider timing,
// enable gaps, software reset requests, timestamp wrap and async reset.
// Edge numbers in comments (eN) count rising edges since reset release.
module tb_clk_rst_sequencer;

    logic clock;
    logic reset;
    logic clk_en;
    logic sw_reset_req;

    int n_cmp;
    int n_fail;

    // Default configuration
    clk_rst_sequencer_if #(.TIME_W(32)) u_if ();
    // Narrow timestamp for wrap checks
    clk_rst_sequencer_if #(.TIME_W(4))  u_if4 ();

    assign u_if.clk_en        = clk_en;
    assign u_if.sw_reset_req  = sw_reset_req;
    assign u_if4.clk_en       = clk_en;
    assign u_if4.sw_reset_req = sw_reset_req;

    clk_rst_sequencer #(.HOLD_CYCLES(10), .HALF_PERIOD(5), .TIME_W(32)) u_dut (
        .clock   (clock),
        .reset   (reset),
        .seq_bus (u_if.master)
    );

    clk_rst_sequencer #(.HOLD_CYCLES(10), .HALF_PERIOD(5), .TIME_W(4)) u_dut4 (
        .clock   (clock),
        .reset   (reset),
        .seq_bus (u_if4.master)
    );

`ifdef CLK_RST_SEQ_EVT_EN
    clk_rst_sequencer_if #(.TIME_W(32)) u_ife ();
    assign u_ife.clk_en       = clk_en;
    assign u_ife.sw_reset_req = sw_reset_req;

    clk_rst_sequencer #(.HOLD_CYCLES(1), .HALF_PERIOD(1), .TIME_W(32)) u_dute (
        .clock   (clock),
        .reset   (reset),
        .seq_bus (u_ife.master)
    );
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and sample just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".sys_reset"}, 64'(u_if.sys_reset), 64'd1);
        chk({tag, ".div_clock"}, 64'(u_if.div_clock), 64'd0);
        chk({tag, ".div_rise"},  64'(u_if.div_rise),  64'd0);
        chk({tag, ".div_fall"},  64'(u_if.div_fall),  64'd0);
        chk({tag, ".timestamp"}, 64'(u_if.timestamp), 64'd0);
        chk({tag, ".seq_state"}, 64'(u_if.seq_state), 64'd0);
        chk({tag, ".ts4"},       64'(u_if4.timestamp), 64'd0);
    endtask

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        reset        = 1'b1;
        clk_en       = 1'b0;
        sw_reset_req = 1'b0;

        // Reset held for 3 cycles
        step(3);
        chk_reset_vals("rst");

        @(negedge clock);
        reset  = 1'b0;
        clk_en = 1'b1;

        // e1
        step(1);
        chk("e1.timestamp", 64'(u_if.timestamp), 64'd1);
        chk("e1.sys_reset", 64'(u_if.sys_reset), 64'd1);
        chk("e1.seq_state", 64'(u_if.seq_state), 64'd0);
`ifdef CLK_RST_SEQ_EVT_EN
        chk("evt.e1.valid", 64'(u_ife.evt_valid), 64'd1);
        chk("evt.e1.count", 64'(u_ife.evt_count), 64'd1);
        chk("evt.e1.sys_reset", 64'(u_ife.sys_reset), 64'd0);
        chk("evt.e1.div_clock", 64'(u_ife.div_clock), 64'd1);
`endif
        // e2
        step(1);
`ifdef CLK_RST_SEQ_EVT_EN
        chk("evt.e2.valid", 64'(u_ife.evt_valid), 64'd1);
        chk("evt.e2.count", 64'(u_ife.evt_count), 64'd2);
`endif
        // e4
        step(2);
        chk("e4.div_clock", 64'(u_if.div_clock), 64'd0);
        // e5: first rise
        step(1);
        chk("e5.div_clock", 64'(u_if.div_clock), 64'd1);
        chk("e5.div_rise",  64'(u_if.div_rise),  64'd1);
        chk("e5.div_fall",  64'(u_if.div_fall),  64'd0);
        // e6
        step(1);
        chk("e6.div_rise",  64'(u_if.div_rise),  64'd0);
        chk("e6.div_clock", 64'(u_if.div_clock), 64'd1);
        // e9: still holding
        step(3);
        chk("e9.sys_reset", 64'(u_if.sys_reset), 64'd1);
        chk("e9.seq_state", 64'(u_if.seq_state), 64'd0);
        // e10: reset released, divider falls
        step(1);
        chk("e10.sys_reset", 64'(u_if.sys_reset), 64'd0);
        chk("e10.seq_state", 64'(u_if.seq_state), 64'd1);
        chk("e10.div_clock", 64'(u_if.div_clock), 64'd0);
        chk("e10.div_fall",  64'(u_if.div_fall),  64'd1);
        chk("e10.div_rise",  64'(u_if.div_rise),  64'd0);
        chk("e10.timestamp", 64'(u_if.timestamp), 64'd10);
        chk("e10.ts4",       64'(u_if4.timestamp), 64'd10);

        // e12: div_cnt=2, then pause the enable for 3 cycles
        step(2);
        @(negedge clock);
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("gap.div_rise",  64'(u_if.div_rise),  64'd0);
            chk("gap.div_fall",  64'(u_if.div_fall),  64'd0);
            chk("gap.div_clock", 64'(u_if.div_clock), 64'd0);
`ifdef CLK_RST_SEQ_EVT_EN
            chk("evt.gap.valid", 64'(u_ife.evt_valid), 64'd0);
            chk("evt.gap.count", 64'(u_ife.evt_count), 64'd12);
`endif
        end
        // e15
        chk("e15.ts4", 64'(u_if4.timestamp), 64'd15);
        @(negedge clock);
        clk_en = 1'b1;
        // e16: narrow timestamp wraps
        step(1);
        chk("e16.ts4",       64'(u_if4.timestamp), 64'd0);
        chk("e16.timestamp", 64'(u_if.timestamp),  64'd16);
        // e17: toggle not yet due (delayed by the gap)
        step(1);
        chk("e17.div_clock", 64'(u_if.div_clock), 64'd0);
        chk("e17.div_rise",  64'(u_if.div_rise),  64'd0);
        // e18: delayed rise
        step(1);
        chk("e18.div_clock", 64'(u_if.div_clock), 64'd1);
        chk("e18.div_rise",  64'(u_if.div_rise),  64'd1);

        // Software reset request in RUN
        @(negedge clock);
        sw_reset_req = 1'b1;
        step(1);                                       // e19
        chk("e19.sys_reset", 64'(u_if.sys_reset), 64'd1);
        chk("e19.seq_state", 64'(u_if.seq_state), 64'd0);
        @(negedge clock);
        sw_reset_req = 1'b0;
        step(4);                                       // e23: divider unaffected
        chk("e23.div_clock", 64'(u_if.div_clock), 64'd0);
        chk("e23.div_fall",  64'(u_if.div_fall),  64'd1);
        step(5);                                       // e28
        chk("e28.sys_reset", 64'(u_if.sys_reset), 64'd1);
        chk("e28.div_rise",  64'(u_if.div_rise),  64'd1);
        step(1);                                       // e29
        chk("e29.sys_reset", 64'(u_if.sys_reset), 64'd0);
        chk("e29.seq_state", 64'(u_if.seq_state), 64'd1);

        // Request again, then re-request on the terminal HOLD edge
        @(negedge clock);
        sw_reset_req = 1'b1;
        step(1);                                       // e30
        chk("e30.sys_reset", 64'(u_if.sys_reset), 64'd1);
        @(negedge clock);
        sw_reset_req = 1'b0;
        step(9);                                       // e39
        chk("e39.sys_reset", 64'(u_if.sys_reset), 64'd1);
        @(negedge clock);
        sw_reset_req = 1'b1;
        step(1);                                       // e40: request wins
        chk("e40.sys_reset", 64'(u_if.sys_reset), 64'd1);
        chk("e40.seq_state", 64'(u_if.seq_state), 64'd0);
        @(negedge clock);
        sw_reset_req = 1'b0;
        step(9);                                       // e49
        chk("e49.sys_reset", 64'(u_if.sys_reset), 64'd1);
        step(1);                                       // e50
        chk("e50.sys_reset", 64'(u_if.sys_reset), 64'd0);
        chk("e50.seq_state", 64'(u_if.seq_state), 64'd1);
        chk("e50.div_clock", 64'(u_if.div_clock), 64'd1);

        // Async reset mid-HOLD and mid-divider-period
        @(negedge clock);
        sw_reset_req = 1'b1;
        step(1);                                       // e51
        chk("e51.seq_state", 64'(u_if.seq_state), 64'd0);
        @(negedge clock);
        sw_reset_req = 1'b0;
        step(7);                                       // e58
        chk("e58.div_rise",  64'(u_if.div_rise),  64'd1);
        step(1);                                       // e59
        chk("e59.div_clock", 64'(u_if.div_clock), 64'd1);
        chk("e59.timestamp", 64'(u_if.timestamp), 64'd59);
        chk("e59.ts4",       64'(u_if4.timestamp), 64'd11);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        step(1);
        chk_reset_vals("held");
        @(negedge clock);
        reset = 1'b0;
        step(1);
        chk("rel.timestamp", 64'(u_if.timestamp), 64'd1);
        chk("rel.sys_reset", 64'(u_if.sys_reset), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
